// File: rtl/nport_mem_pkg.sv
// Shared encodings and helpers for the N-port synchronous memory.
package nport_mem_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int RDW_OLD   = 0;
    localparam int RDW_NEW   = 1;
    localparam int MAX_PORTS = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Request vectors are zero-extended to MAX_PORTS before counting.
    function automatic int unsigned popcount(input logic [MAX_PORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_PORTS; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/nport_rr_arbiter.sv
// Single-winner write arbiter: fixed priority from port 0, or round-robin from rr_ptr.
module nport_rr_arbiter
    import nport_mem_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic              mode,
    output logic [NPORTS-1:0] gnt_onehot,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Both modes share one wrapping search; fixed priority simply starts at 0.
    always_comb begin
        int start;
        int idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        start      = (mode == 1'b1) ? int'(rr_ptr_q) : 0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = start + k;
            if (idx >= NPORTS) idx -= NPORTS;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
        if (gnt_valid) begin
            gnt_onehot[gnt_idx] = 1'b1;
            if (mode == 1'b1)
                rr_ptr_d = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/nport_sync_mem.sv
// N-port synchronous memory: one arbitrated write per cycle, registered reads,
// optional zeroing sweep after reset, saturating count of dropped writes.
module nport_sync_mem
    import nport_mem_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ADDR_W         = 4,
    parameter int NPORTS         = 3,
    parameter int ARB_MODE       = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*WIDTH-1:0]  wdata,
    output logic [NPORTS*WIDTH-1:0]  rdata,
    output logic [NPORTS-1:0]        rvalid,
    output logic [NPORTS-1:0]        wgrant,
    output logic                     init_busy,
    output logic [CNT_W-1:0]         coll_cnt
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam int          IDX_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         sweep_q, sweep_d;
    logic [NPORTS*WIDTH-1:0]   rdata_q, rdata_d;
    logic [NPORTS-1:0]         rvalid_q, rvalid_d;
    logic [NPORTS-1:0]         wgrant_q, wgrant_d;
    logic [CNT_W-1:0]          coll_cnt_q, coll_cnt_d;
    logic [WIDTH-1:0]          mem_q [DEPTH];

    logic [NPORTS-1:0]         req, gnt_onehot;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_valid;
    logic [ADDR_W-1:0]         waddr_g;
    logic [WIDTH-1:0]          wdata_g;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [WIDTH-1:0]          mem_wdata;
    logic [31:0]               losers, cnt_sum;

    // Requests are masked during the sweep so the arbiter and rr_ptr stay idle.
    assign req = (state_q == ST_RUN) ? we : '0;

    nport_rr_arbiter #(.NPORTS(NPORTS), .IDX_W(IDX_W)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       ((ARB_MODE == ARB_RR) ? 1'b1 : 1'b0),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    assign waddr_g = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign wdata_g = wdata[int'(gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = waddr_g;
        mem_wdata = wdata_g;
        wgrant_d  = gnt_onehot;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
            sweep_d   = sweep_q + 1'b1;
            if (sweep_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
        end else if (gnt_valid) begin
            mem_we = 1'b1;
        end
    end

    // New-data mode forwards the winning write to readers of the same address.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (state_q == ST_RUN && !we[i]) begin
                rvalid_d[i] = 1'b1;
                if (RDW_MODE == RDW_NEW && gnt_valid &&
                    addr[i*ADDR_W +: ADDR_W] == waddr_g)
                    rdata_d[i*WIDTH +: WIDTH] = wdata_g;
                else
                    rdata_d[i*WIDTH +: WIDTH] = mem_q[addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_comb begin
        losers     = gnt_valid ? popcount(MAX_PORTS'(req)) - 32'd1 : 32'd0;
        cnt_sum    = 32'(coll_cnt_q) + losers;
        coll_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            sweep_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            wgrant_q   <= '0;
            coll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wgrant_q   <= wgrant_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    // Array is not reset; a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign wgrant    = wgrant_q;
    assign init_busy = (state_q == ST_INIT);
    assign coll_cnt  = coll_cnt_q;

endmodule

// File: doc/nport_sync_mem.md
Name: nport_sync_mem

Overview:
Parametrised N-port synchronous memory; next generation of the team's fixed three-port memory. Any port may read or write each cycle. At most one write commits per cycle, chosen by a fixed-priority or round-robin arbiter; losing writes are dropped and counted. Reads are registered with a selectable read-during-write policy, and an optional post-reset clear sweep zeroes the array before normal operation.

Parameters:
WIDTH, 8, data bits per word
ADDR_W, 4, address bits; DEPTH = 2**ADDR_W words
NPORTS, 3, number of ports (>=1)
ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
RDW_MODE, 0, same-cycle read of the address being written: 0 = old data, 1 = new data
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear
CNT_W, 8, width of the collision counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset, sampled on posedge clk
we  in  NPORTS  per-port write request; 0 = read
addr  in  NPORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
wdata  in  NPORTS*WIDTH  port i at [i*WIDTH +: WIDTH]
rdata  out  NPORTS*WIDTH  registered read data, port i at [i*WIDTH +: WIDTH]
rvalid  out  NPORTS  rdata[i] updated this cycle
wgrant  out  NPORTS  one-hot (or zero); port i's write committed last cycle
init_busy  out  1  clear sweep in progress; port requests ignored
coll_cnt  out  CNT_W  saturating count of dropped writes

Behaviour:
- Reset (rst=0 at posedge):
  - rdata=0, rvalid=0, wgrant=0, coll_cnt=0, rr_ptr=0, sweep address=0.
  - State becomes INIT if CLEAR_ON_RESET=1, else RUN. init_busy=1 in INIT, 0 in RUN.
- Reset mid-operation: in-flight reads and writes are discarded. If CLEAR_ON_RESET=1, the clear restarts from address 0.
- States: INIT, RUN. No other states.
- INIT:
  - Each cycle writes 0 to mem[sweep_addr], then sweep_addr+1.
  - After the write at DEPTH-1, transitions to RUN. init_busy is high for exactly DEPTH cycles after rst rises.
  - we, addr and wdata are ignored. rvalid=0, wgrant=0, coll_cnt held.
- RUN, write arbitration (per cycle):
  - Requesters R = we. If R=0, no write occurs.
  - ARB_MODE=0: grant goes to the lowest i in R.
  - ARB_MODE=1: grant goes to the first i in R searching upward from rr_ptr, wrapping at NPORTS. On a grant, rr_ptr <= (g+1) mod NPORTS; otherwise rr_ptr is unchanged.
  - mem[addr[g]] <= wdata[g] at the edge. wgrant <= onehot(g), valid for one cycle.
  - Losers (popcount(R)-1) are dropped with no retry. coll_cnt += losers, saturating at 2**CNT_W-1.
  - Same-address and different-address collisions are treated identically.
- RUN, reads:
  - Every port with we[i]=0 latches rdata[i] <= mem[addr[i]] at the edge, and rvalid[i] <= 1. Latency is 1 cycle.
  - Ports with we[i]=1 get rvalid[i] <= 0; rdata[i] holds its previous value.
  - Read-during-write (read addr == addr[g] in the same cycle): RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns wdata[g]. The address compare uses the full ADDR_W bits.
- Every address in 0..DEPTH-1 is valid; there is no out-of-range case.
- NPORTS=1: the arbiter degenerates to a pass-through, and coll_cnt stays 0.

Decomposition:
- Package nport_mem_pkg holds:
  - ARB_FIXED=0 and ARB_RR=1
  - RDW_OLD=0 and RDW_NEW=1
  - state encoding ST_INIT / ST_RUN
  - a popcount function sized for NPORTS
- Sub-module nport_rr_arbiter(clk, rst, req[NPORTS], mode, gnt_onehot, gnt_idx, gnt_valid) owns rr_ptr and both arbitration modes.
- The top level holds the array, the sweep FSM, the read registers and coll_cnt.

Test Plan:
1. CLEAR_ON_RESET=1, memory preloaded non-zero, rst low 2 cycles then high -> init_busy high exactly 16 cycles. Port requests during the sweep are ignored. Afterwards every address reads 0x00 with rvalid=1, one cycle after the request.
2. ARB_MODE=0, ports 0,1,2 write addr 5/6/7 with data 0xA0/0xB0/0xC0 in one cycle -> wgrant=3'b001 next cycle, mem[5]=0xA0, mem[6] and mem[7] unchanged, coll_cnt=2.
3. ARB_MODE=1, all three ports request every cycle for 6 cycles -> wgrant sequence 001,010,100,001,010,100; coll_cnt=12.
4. RDW: port 0 writes 0x55 to addr 3 (old value 0x11) while port 1 reads addr 3 -> rdata1=0x11 with RDW_MODE=0; rdata1=0x55 with RDW_MODE=1. Both with rvalid1=1 next cycle.
5. CNT_W=2, three-way collision held 3 cycles -> coll_cnt goes 2, then 3, then stays 3 (saturated).
6. rst pulsed low for one cycle midway through the sweep and again in RUN with pending writes -> sweep restarts at address 0. The pending write is not committed, and wgrant=0, rvalid=0, coll_cnt=0 on the cycle after reset.
